// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared constants and helpers for the ALU reservation station
// Purpose: ROB tag width, default station geometry, RISC-V opcode constants
//          and the CDB tag-match helper used by alu_rs.
// Ports:   none (package)
package alu_rs_pkg;

  localparam int ROB_BIT     = 4;
  localparam int RS_SIZE_DEF = 8;
  localparam int RS_BIT_DEF  = 3;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // True when a broadcasting CDB carries the tag an operand is waiting on.
  function automatic logic cdb_match(input logic ready,
                                     input logic [ROB_BIT-1:0] cdb_tag,
                                     input logic [ROB_BIT-1:0] wait_tag);
    return ready && (cdb_tag == wait_tag);
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - lowest-index priority encoder
// Purpose: finds the lowest set bit of a request vector.
// Ports:   req   in  N  request vector
//          found out 1  any request set
//          idx   out W  index of the lowest set request (0 when none)
module rs_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top so the lowest index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding the integer ALU
// Purpose: holds dispatched OP/OP-IMM/BRANCH instructions until both operands
//          are known, snoops both CDBs, issues one ready entry per cycle as a
//          registered bundle, and is flushed by the ROB.
// Ports:   clk_in, rst_in (async, active high), rdy_in (pause), clear (flush)
//          issue_*        dispatch request and decoded instruction
//          rs_full        no free entry
//          cdb_alu_*, cdb_lsb_*  result broadcasts
//          alu_*          registered issue bundle to the ALU
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int RS_BIT  = RS_BIT_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               issue_valid,
  input  logic [2:0]         issue_op,
  input  logic [6:0]         issue_op_type,
  input  logic               issue_op_addition,
  input  logic [31:0]        issue_vi,
  input  logic [31:0]        issue_vj,
  input  logic               issue_qi_valid,
  input  logic               issue_qj_valid,
  input  logic [ROB_BIT-1:0] issue_qi,
  input  logic [ROB_BIT-1:0] issue_qj,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  output logic               rs_full,
  input  logic               cdb_alu_ready,
  input  logic [31:0]        cdb_alu_res,
  input  logic [ROB_BIT-1:0] cdb_alu_rob,
  input  logic               cdb_lsb_ready,
  input  logic [31:0]        cdb_lsb_res,
  input  logic [ROB_BIT-1:0] cdb_lsb_rob,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [2:0]         alu_op,
  output logic [6:0]         alu_op_type,
  output logic               alu_op_addition,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qi_valid;
  logic [RS_SIZE-1:0] qj_valid;
  logic [RS_SIZE-1:0] op_addition;
  logic [2:0]         op      [RS_SIZE];
  logic [6:0]         op_type [RS_SIZE];
  logic [31:0]        vi      [RS_SIZE];
  logic [31:0]        vj      [RS_SIZE];
  logic [ROB_BIT-1:0] qi      [RS_SIZE];
  logic [ROB_BIT-1:0] qj      [RS_SIZE];
  logic [ROB_BIT-1:0] rob     [RS_SIZE];
  logic [RS_BIT:0]    count;

  logic              free_found, ready_found;
  logic [RS_BIT-1:0] free_idx, ready_idx;
  logic              alloc, do_issue;
  logic [31:0]       new_vi, new_vj;
  logic              new_qi_valid, new_qj_valid;

  assign rs_full = (count == (RS_BIT + 1)'(RS_SIZE));

  rs_pick #(.N(RS_SIZE), .W(RS_BIT)) u_free_pick (
    .req   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  // Readiness is judged on registered tags only, so a wakeup this cycle
  // becomes selectable next cycle.
  rs_pick #(.N(RS_SIZE), .W(RS_BIT)) u_ready_pick (
    .req   (busy & ~qi_valid & ~qj_valid),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign alloc    = issue_valid && !clear && !rs_full && free_found;
  assign do_issue = ready_found && !clear;

  // Dispatch bypass: a result broadcast in the dispatch cycle is folded in
  // directly, otherwise the entry would miss it forever. ALU bus wins a tie.
  always_comb begin
    new_vi       = issue_vi;
    new_vj       = issue_vj;
    new_qi_valid = issue_qi_valid;
    new_qj_valid = issue_qj_valid;
    if (issue_qi_valid) begin
      if (cdb_match(cdb_alu_ready, cdb_alu_rob, issue_qi)) begin
        new_vi       = cdb_alu_res;
        new_qi_valid = 1'b0;
      end else if (cdb_match(cdb_lsb_ready, cdb_lsb_rob, issue_qi)) begin
        new_vi       = cdb_lsb_res;
        new_qi_valid = 1'b0;
      end
    end
    if (issue_qj_valid) begin
      if (cdb_match(cdb_alu_ready, cdb_alu_rob, issue_qj)) begin
        new_vj       = cdb_alu_res;
        new_qj_valid = 1'b0;
      end else if (cdb_match(cdb_lsb_ready, cdb_lsb_rob, issue_qj)) begin
        new_vj       = cdb_lsb_res;
        new_qj_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy            <= '0;
      qi_valid        <= '0;
      qj_valid        <= '0;
      op_addition     <= '0;
      count           <= '0;
      alu_valid       <= 1'b0;
      alu_vi          <= '0;
      alu_vj          <= '0;
      alu_op          <= '0;
      alu_op_type     <= '0;
      alu_op_addition <= 1'b0;
      alu_rob_entry   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]      <= '0;
        op_type[i] <= '0;
        vi[i]      <= '0;
        vj[i]      <= '0;
        qi[i]      <= '0;
        qj[i]      <= '0;
        rob[i]     <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        busy      <= '0;
        count     <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qi_valid[i]) begin
            if (cdb_match(cdb_alu_ready, cdb_alu_rob, qi[i])) begin
              vi[i]       <= cdb_alu_res;
              qi_valid[i] <= 1'b0;
            end else if (cdb_match(cdb_lsb_ready, cdb_lsb_rob, qi[i])) begin
              vi[i]       <= cdb_lsb_res;
              qi_valid[i] <= 1'b0;
            end
          end
          if (busy[i] && qj_valid[i]) begin
            if (cdb_match(cdb_alu_ready, cdb_alu_rob, qj[i])) begin
              vj[i]       <= cdb_alu_res;
              qj_valid[i] <= 1'b0;
            end else if (cdb_match(cdb_lsb_ready, cdb_lsb_rob, qj[i])) begin
              vj[i]       <= cdb_lsb_res;
              qj_valid[i] <= 1'b0;
            end
          end
        end

        // free_idx is never busy and ready_idx always is, so these writes
        // cannot collide with each other or with the wakeup above.
        if (alloc) begin
          busy[free_idx]        <= 1'b1;
          op[free_idx]          <= issue_op;
          op_type[free_idx]     <= issue_op_type;
          op_addition[free_idx] <= issue_op_addition;
          vi[free_idx]          <= new_vi;
          vj[free_idx]          <= new_vj;
          qi_valid[free_idx]    <= new_qi_valid;
          qj_valid[free_idx]    <= new_qj_valid;
          qi[free_idx]          <= issue_qi;
          qj[free_idx]          <= issue_qj;
          rob[free_idx]         <= issue_rob_entry;
        end

        alu_valid <= do_issue;
        if (do_issue) begin
          busy[ready_idx] <= 1'b0;
          alu_vi          <= vi[ready_idx];
          alu_vj          <= vj[ready_idx];
          alu_op          <= op[ready_idx];
          alu_op_type     <= op_type[ready_idx];
          alu_op_addition <= op_addition[ready_idx];
          alu_rob_entry   <= rob[ready_idx];
        end

        count <= count + {{RS_BIT{1'b0}}, alloc} - {{RS_BIT{1'b0}}, do_issue};
      end
    end
  end

endmodule
